// File: rtl/branch_pc_unit.sv
// branch_pc_unit: branch resolution, PC register, misalign trap FSM and branch counters
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_brc_less,
  input  logic             i_brc_equal,
  input  logic [31:0]      i_target,
  output logic             o_br_un,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_four,
  output logic             o_taken,
  output logic             o_valid,
  output logic             o_misalign,
  output logic [31:0]      o_mtval,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_nx;
  logic run, legal, cond, br, br_tk, fault;
  logic [31:0] eff;
  assign run       = (state == RUN);
  assign o_br_un   = i_funct3[1];
  assign o_pc_four = o_pc + 32'd4;
  assign o_valid   = run;
  assign o_misalign = ~run;
  // funct3 010/011 are the only illegal encodings
  assign legal = ~(~i_funct3[2] & i_funct3[1]);
  assign cond  = (i_funct3[2] ? i_brc_less : i_brc_equal) ^ i_funct3[0];
  assign br    = run & ~i_is_jalr & ~i_is_jal & i_is_branch & legal;
  assign br_tk = br & cond;
  assign o_taken = run & (i_is_jalr | i_is_jal | br_tk);
  assign eff   = i_is_jalr ? {i_target[31:1], 1'b0} : i_target;
  assign fault = o_taken & (eff[1:0] != 2'b00);
  always_comb begin
    state_nx = state;
    if (state == TRAP) state_nx = RUN;
    else if (fault) state_nx = TRAP;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RUN;
      o_pc        <= RESET_PC;
      o_mtval     <= '0;
      o_br_cnt    <= '0;
      o_taken_cnt <= '0;
    end else if (!i_stall) begin
      state <= state_nx;
      if (run) begin
        o_pc        <= fault ? TRAP_VEC : (o_taken ? eff : o_pc_four);
        o_br_cnt    <= o_br_cnt + CNT_W'(br);
        o_taken_cnt <= o_taken_cnt + CNT_W'(br_tk);
        if (fault) o_mtval <= eff;
      end
    end
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vectors checked against a behavioural model every cycle
module tb_branch_pc_unit;
  logic clk = 0, rst = 1, stall = 0, is_branch = 0, is_jal = 0, is_jalr = 0;
  logic [2:0] funct3 = 0;
  logic less = 0, equal = 0;
  logic [31:0] target = 0;
  logic br_un, taken, valid, misalign, br_un4, taken4, valid4, misalign4;
  logic [31:0] pc, pc_four, mtval, br_cnt, taken_cnt, pc4, pc_four4, mtval4;
  logic [3:0] br_cnt4, taken_cnt4;
  int checks = 0, errors = 0;
  logic chk_en = 0;
  logic [31:0] m_pc, m_mtval, m_br, m_tk;
  logic m_trap;

  always #5 clk = ~clk;

  branch_pc_unit dut (.i_clk(clk), .i_rst(rst), .i_stall(stall), .i_is_branch(is_branch),
    .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_funct3(funct3), .i_brc_less(less),
    .i_brc_equal(equal), .i_target(target), .o_br_un(br_un), .o_pc(pc), .o_pc_four(pc_four),
    .o_taken(taken), .o_valid(valid), .o_misalign(misalign), .o_mtval(mtval),
    .o_br_cnt(br_cnt), .o_taken_cnt(taken_cnt));

  branch_pc_unit #(.CNT_W(4)) dut4 (.i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_funct3(funct3),
    .i_brc_less(less), .i_brc_equal(equal), .i_target(target), .o_br_un(br_un4), .o_pc(pc4),
    .o_pc_four(pc_four4), .o_taken(taken4), .o_valid(valid4), .o_misalign(misalign4),
    .o_mtval(mtval4), .o_br_cnt(br_cnt4), .o_taken_cnt(taken_cnt4));

  // Which instruction class is active, by priority jalr > jal > branch
  function automatic int kind();
    if (is_jalr) return 3;
    if (is_jal) return 2;
    if (is_branch) return 1;
    return 0;
  endfunction

  // Branch outcome table: -1 illegal, 0 not taken, 1 taken
  function automatic int br_outcome();
    case (funct3)
      3'd0: return equal ? 1 : 0;
      3'd1: return equal ? 0 : 1;
      3'd4, 3'd6: return less ? 1 : 0;
      3'd5, 3'd7: return less ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic exp_taken();
    if (m_trap) return 0;
    if (kind() >= 2) return 1;
    return kind() == 1 && br_outcome() == 1;
  endfunction

  function automatic logic [31:0] exp_target();
    return kind() == 3 ? (target & 32'hFFFF_FFFE) : target;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_trap <= 0; m_mtval <= 0; m_br <= 0; m_tk <= 0;
    end else if (!stall) begin
      if (m_trap) m_trap <= 0;
      else begin
        if (kind() == 1 && br_outcome() >= 0) m_br <= m_br + 1;
        if (kind() == 1 && br_outcome() == 1) m_tk <= m_tk + 1;
        if (exp_taken() && exp_target() % 4 != 0) begin
          m_pc <= 32'h100; m_mtval <= exp_target(); m_trap <= 1;
        end else m_pc <= exp_taken() ? exp_target() : m_pc + 4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("pc", pc, m_pc);
    chk("pc_four", pc_four, m_pc + 32'd4);
    chk("valid", {31'b0, valid}, {31'b0, !m_trap});
    chk("misalign", {31'b0, misalign}, {31'b0, m_trap});
    chk("mtval", mtval, m_mtval);
    chk("br_cnt", br_cnt, m_br);
    chk("taken_cnt", taken_cnt, m_tk);
    chk("br_cnt4", {28'b0, br_cnt4}, {28'b0, m_br[3:0]});
    chk("taken_cnt4", {28'b0, taken_cnt4}, {28'b0, m_tk[3:0]});
    chk("taken", {31'b0, taken}, {31'b0, exp_taken()});
    chk("br_un", {31'b0, br_un}, {29'b0, funct3} >> 1 & 32'd1);
  end

  task automatic set(input logic b, input logic j, input logic jr, input logic [2:0] f,
                     input logic l, input logic e, input logic [31:0] t);
    is_branch = b; is_jal = j; is_jalr = jr; funct3 = f; less = l; equal = e; target = t;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    set(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk_en = 1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd1);
    chk("rst_br_cnt", br_cnt, 32'd0);
    rst = 0;
    step(); chk("nop1", pc, 32'd4);
    step(); chk("nop2", pc, 32'd8);
    step(); chk("nop3", pc, 32'd12);
    set(1, 0, 0, 3'b110, 1, 0, 32'h40);
    chk("bltu_br_un", {31'b0, br_un}, 32'd1);
    chk("bltu_taken", {31'b0, taken}, 32'd1);
    step();
    chk("bltu_pc", pc, 32'h40); chk("bltu_br", br_cnt, 1); chk("bltu_tk", taken_cnt, 1);
    set(1, 0, 0, 3'b101, 1, 0, 32'h80);
    step();
    chk("bge_pc", pc, 32'h44); chk("bge_br", br_cnt, 2); chk("bge_tk", taken_cnt, 1);
    set(0, 0, 1, 0, 0, 0, 32'h0000_0123);
    step();
    chk("jalr_mis", {31'b0, misalign}, 32'd1); chk("jalr_valid", {31'b0, valid}, 32'd0);
    chk("jalr_pc", pc, 32'h100); chk("jalr_mtval", mtval, 32'h122);
    set(0, 1, 0, 0, 0, 0, 32'h200);
    chk("trap_taken", {31'b0, taken}, 32'd0);
    step();
    chk("trap_exit_valid", {31'b0, valid}, 32'd1); chk("trap_exit_pc", pc, 32'h100);
    set(1, 0, 0, 3'b000, 0, 1, 32'h180);
    stall = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", pc, 32'h100); chk("stall_tk", taken_cnt, 1); chk("stall_br", br_cnt, 2);
    stall = 0;
    step();
    chk("unstall_pc", pc, 32'h180); chk("unstall_tk", taken_cnt, 2);
    set(0, 0, 0, 0, 0, 0, 0);
    step(); chk("after_pc", pc, 32'h184);
    set(1, 0, 0, 3'b010, 0, 1, 32'h300);
    chk("illegal_taken", {31'b0, taken}, 32'd0);
    step(); chk("illegal_pc", pc, 32'h188); chk("illegal_br", br_cnt, 3);
    set(1, 1, 0, 3'b000, 0, 1, 32'h400);
    step(); chk("jal_br_pc", pc, 32'h400); chk("jal_br_cnt", br_cnt, 3);
    set(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step(); chk("wrap_four", pc_four, 32'h0);
    set(0, 0, 0, 0, 0, 0, 0);
    step(); chk("wrap_pc", pc, 32'h0);
    set(1, 0, 0, 3'b000, 0, 1, 32'h6);
    step();
    chk("bfault_mtval", mtval, 32'h6); chk("bfault_tk", taken_cnt, 3); chk("bfault_br", br_cnt, 4);
    set(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    chk("trap_rst_pc", pc, 32'h0); chk("trap_rst_valid", {31'b0, valid}, 32'd1);
    chk("trap_rst_mtval", mtval, 32'h0);
    set(1, 0, 0, 3'b001, 0, 1, 32'h800);
    for (int i = 0; i < 16; i++) step();
    chk("wrap4_br", {28'b0, br_cnt4}, 32'd0); chk("wrap32_br", br_cnt, 32'd16);
    set(0, 0, 0, 0, 0, 0, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
